// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, one-byte holding register.
// Optional even-parity support is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;
`endif

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      idx, idx_next;
  logic [7:0]      shift, shift_next;
  logic            rx_meta, rx_s;
  logic [1:0]      prime;
  logic            armed;
  logic            byte_done, done_next;
  logic            ferr_next;

  // Both synchronizer flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // rx_s only reflects the real line two edges after reset; a start is accepted
  // only once the line has been seen high, so a low line at release is ignored.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      prime <= 2'b00;
      armed <= 1'b0;
    end else begin
      prime <= {prime[0], 1'b1};
      if (prime[1] && rx_s) armed <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad, pbad_next;
  logic perr_next, parity_err_r;
  assign parity_err_o = parity_err_r;
`else
  assign parity_err_o = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_next  = parity_bad;
    perr_next  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (armed && !rx_s) begin
          state_next = S_START;
          cnt_next   = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
            cnt_next   = FULL_LOAD;
            idx_next   = 3'd0;
`ifdef UART_RX_PARITY_EN
            pbad_next  = 1'b0;
`endif
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shift_next = {rx_s, shift[7:1]};
          cnt_next   = FULL_LOAD;
          idx_next   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == '0) begin
          if (rx_s != ^shift) begin
            perr_next = 1'b1;
            pbad_next = 1'b1;
          end
          cnt_next   = FULL_LOAD;
          state_next = S_STOP;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
            done_next  = !parity_bad;
`else
            done_next  = 1'b1;
`endif
          end else begin
            ferr_next  = 1'b1;
            state_next = S_WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shift       <= 8'h00;
      byte_done   <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      shift       <= shift_next;
      byte_done   <= done_next;
      frame_err_o <= ferr_next;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= pbad_next;
      parity_err_r <= perr_next;
`endif
    end
  end

  // Holding register: a completed byte loads when empty or drained on the same edge.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      data_o    <= 8'h00;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (byte_done) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus a randomized frame stream
// checked against a frame-level model (expected byte queue and error counts).
module tb_uart_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  int perr_cnt  = 0;
  int valid_cyc = 0;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk = ~clk;

  // Outputs are observed on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (valid_o && ready_i) rx_q.push_back(data_o);
    if (valid_o)      valid_cyc++;
    if (frame_err_o)  ferr_cnt++;
    if (overrun_o)    ovr_cnt++;
    if (parity_err_o) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    tick(C);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit !== 1'bx) rx_i = rx_i;
`endif
    drive_bit(stop_bit);
    rx_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_raw(b, ^b, stop_bit);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    check({tag, "_count"}, rx_q.size(), 1);
    if (rx_q.size() > 0) check({tag, "_data"}, rx_q.pop_front(), exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  data_o,       8'h00);
    check({tag, "_valid"}, valid_o,      1'b0);
    check({tag, "_ferr"},  frame_err_o,  1'b0);
    check({tag, "_ovr"},   overrun_o,    1'b0);
    check({tag, "_perr"},  parity_err_o, 1'b0);
  endtask

  initial begin
    int f0, o0, p0, v0;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    reset_i = 1'b0;
    tick(3);
    check_outputs_zero("reset");
    reset_i = 1'b1;
    tick(2 * C);

    // Single good frame, consumer always ready.
    f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt; v0 = valid_cyc;
    send_frame(8'hA5, 1'b1);
    tick(2 * C);
    expect_byte("a5", 8'hA5);
    check("a5_valid_cycles", valid_cyc - v0, 1);
    check("a5_ferr", ferr_cnt - f0, 0);
    check("a5_ovr",  ovr_cnt - o0, 0);
    check("a5_perr", perr_cnt - p0, 0);

    // Back-to-back frames into a stalled consumer: second byte is dropped.
    ready_i = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick(C);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_valid",  valid_o, 1'b1);
    check("ovr_held",   data_o, 8'h3C);
    check("ovr_none_taken", rx_q.size(), 0);
    ready_i = 1'b1;
    tick(2);
    expect_byte("ovr_drain", 8'h3C);
    check("ovr_cleared", valid_o, 1'b0);

    // Bad stop bit followed by a long break, then recovery.
    f0 = ferr_cnt; v0 = valid_cyc;
    send_frame(8'h55, 1'b0);
    rx_i = 1'b0;
    tick(40 * C);
    rx_i = 1'b1;
    tick(2 * C);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_valid", valid_cyc - v0, 0);
    check("break_no_byte", rx_q.size(), 0);
    send_frame(8'h12, 1'b1);
    tick(2 * C);
    expect_byte("after_break", 8'h12);

    // Short glitch is rejected as a false start.
    f0 = ferr_cnt; v0 = valid_cyc;
    rx_i = 1'b0;
    tick(5);
    rx_i = 1'b1;
    tick(2 * C);
    check("glitch_valid", valid_cyc - v0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    send_frame(8'hFF, 1'b1);
    tick(2 * C);
    expect_byte("after_glitch", 8'hFF);

    // Reset in the middle of bit 4 of 8'h81; the rest of the data bits follow.
    f0 = ferr_cnt; v0 = valid_cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i));
    rx_i = 1'b0;
    tick(C / 2);
    reset_i = 1'b0;
    tick(2);
    check_outputs_zero("midreset");
    reset_i = 1'b1;
    tick(C / 2);
    for (int i = 5; i < 8; i++) drive_bit(1'(8'h81 >> i));
    rx_i = 1'b1;
    tick(3 * C);
    check("midreset_no_byte", rx_q.size(), 0);
    check("midreset_valid", valid_cyc - v0, 0);
    check("midreset_ferr", ferr_cnt - f0, 0);
    send_frame(8'h7E, 1'b1);
    tick(2 * C);
    expect_byte("after_reset", 8'h7E);

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt; v0 = valid_cyc;
    send_raw(8'h01, 1'b0, 1'b1);
    tick(2 * C);
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_valid", valid_cyc - v0, 0);
    send_raw(8'h01, 1'b1, 1'b1);
    tick(2 * C);
    expect_byte("par_good", 8'h01);
`endif

    // Randomized frame stream against the frame-level model.
    begin
      int exp_ferr, exp_perr;
      exp_ferr = 0; exp_perr = 0;
      f0 = ferr_cnt; p0 = perr_cnt; o0 = ovr_cnt;
      exp_q.delete();
      rx_q.delete();
      for (int n = 0; n < 24; n++) begin
        logic [7:0] b;
        logic       stop_ok, par_ok;
        int         gap;
        b       = 8'($urandom);
        stop_ok = ($urandom_range(0, 4) != 0);
        par_ok  = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_ok  = ($urandom_range(0, 5) != 0);
`endif
        gap = $urandom_range(0, 2 * C);
        if (!stop_ok && gap < 2) gap = 2;
        send_raw(b, (^b) ^ !par_ok, stop_ok);
        if (!par_ok) exp_perr++;
        if (!stop_ok) exp_ferr++;
        if (stop_ok && par_ok) exp_q.push_back(b);
        tick(gap);
      end
      tick(2 * C);
      check("rand_count", rx_q.size(), exp_q.size());
      while (rx_q.size() > 0 && exp_q.size() > 0)
        check("rand_byte", rx_q.pop_front(), exp_q.pop_front());
      check("rand_ferr", ferr_cnt - f0, exp_ferr);
      check("rand_perr", perr_cnt - p0, exp_perr);
      check("rand_ovr",  ovr_cnt - o0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-low reset; asserts immediately, releases on the rising edge of clk.
REQ-004 rx_i  input  1  asynchronous serial line; idle high.
REQ-005 data_o  output  8  received byte; valid while valid_o=1.
REQ-006 valid_o  output  1  byte available in the holding register.
REQ-007 ready_i  input  1  consumer accepts data_o when valid_o=1 and ready_i=1 on the same edge.
REQ-008 frame_err_o  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 overrun_o  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.
REQ-010 parity_err_o  output  1  one-cycle pulse when the parity check fails (see Configuration).

Function
REQ-011 rx_i SHALL pass through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
REQ-014 IDLE -> START on the first cycle rx_s=0; the bit counter SHALL load CLKS_PER_BIT/2 - 1 (integer division).
REQ-015 START: at counter expiry, sample rx_s; 1 -> IDLE (false start, no output, no error); 0 -> DATA with counter = CLKS_PER_BIT-1.
REQ-016 DATA: at each counter expiry, sample rx_s into bit[index]; index 0..7; after bit 7 -> PARITY (macro) or STOP.
REQ-017 STOP: at counter expiry, sample rx_s; 1 -> frame good, IDLE; 0 -> frame_err_o pulse, byte discarded, WAIT_IDLE.
REQ-018 WAIT_IDLE -> IDLE on the first cycle rx_s=1; a break (line held low) SHALL produce exactly one frame_err_o pulse.
REQ-019 Good frame: on the edge after the stop sample, data_o SHALL load the byte and valid_o SHALL be 1, provided the holding register is empty or accepted on that same edge.
REQ-020 Latency: stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+CLKS_PER_BIT with parity) cycles after IDLE->START; valid_o rises one cycle later.
REQ-021 valid_o SHALL remain 1 and data_o stable until a valid_o&&ready_i edge; then valid_o clears unless a new byte loads on that same edge (valid_o stays 1, data_o updates, no overrun).
REQ-022 Good frame completing while valid_o=1 and ready_i=0: new byte dropped, old byte retained, overrun_o pulses one cycle.
REQ-023 A new start bit SHALL be accepted in the cycle the FSM returns to IDLE; back-to-back frames with no idle gap SHALL be received.
REQ-024 Bit counter width SHALL be $clog2(CLKS_PER_BIT); no counter wrap while in IDLE.

Reset
REQ-025 While reset_i=0: FSM=IDLE, counters=0, data_o=8'h00, valid_o=0, frame_err_o=0, overrun_o=0, parity_err_o=0, synchronizer=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output; after release a frame SHALL be received only from a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state present; even parity over the 8 data bits; mismatch -> parity_err_o pulse and byte discarded (no valid_o), stop bit still checked (frame_err_o may pulse in the same frame).
REQ-028 UART_RX_PARITY_EN undefined: no PARITY state, frame is 10 bits, parity_err_o tied to 0.

Verification (CLKS_PER_BIT=16, 10 ns clk, no macro unless stated)
REQ-029 Send 8'hA5 framed correctly, ready_i=1 -> data_o=8'hA5, valid_o high exactly 1 cycle, no error pulses.
REQ-030 Send 8'h3C then 8'hC3 back-to-back, ready_i=0 -> valid_o=1, data_o=8'h3C held, overrun_o one pulse at second frame end.
REQ-031 Send 8'h55 with stop bit 0, then line held low 40 bit-times -> one frame_err_o pulse, valid_o stays 0; next good 8'h12 received.
REQ-032 Glitch: rx_i low 5 cycles then high -> false start, no valid_o, no error; following 8'hFF received.
REQ-033 Assert reset_i=0 during bit 4 of 8'h81, release -> all outputs 0; next frame 8'h7E received correctly.
REQ-034 With UART_RX_PARITY_EN: 8'h01 with parity bit 0 -> parity_err_o pulse, no valid_o; 8'h01 with parity bit 1 -> data_o=8'h01.
